// File: rtl/bnw_pkg.sv
// Shared constants and types for the BNW piano game lane logic.
// Positions are in the pixel generator's translated vertical coordinate
// (v_cnt + 120), so the visible screen spans 120..599.
package bnw_pkg;

   localparam int NUM_SLOTS = 6;
   localparam int H_W       = 10;

   localparam int BLOCK_H  = 120;
   // A fresh block sits with its bottom edge on the top screen line.
   localparam int SPAWN_H  = BLOCK_H;
   localparam int HIT_LO   = 468;
   localparam int HIT_HI   = 599;
   localparam int RETIRE_H = 720;

   typedef logic [H_W-1:0] pos_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE
   } lane_state_e;

   // True when a block's bottom edge lies inside the judgement band.
   function automatic logic in_hit_window(input pos_t h);
      return (h >= pos_t'(HIT_LO)) && (h <= pos_t'(HIT_HI));
   endfunction

endpackage

// File: rtl/lane_slot_alloc.sv
// Combinational lowest-index priority encoder over the lane's slots.
// Used for free-slot selection on spawn and for picking the hit target
// among the largest-h candidates.
module lane_slot_alloc
   import bnw_pkg::*;
(
   input  logic [NUM_SLOTS-1:0] req,
   output logic [NUM_SLOTS-1:0] grant,
   output logic                 none
);

   // Scan high to low so the last (lowest) requesting index wins.
   always_comb begin
      grant = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant = NUM_SLOTS'(1) << i;
         end
      end
      none = ~|req;
   end

endmodule

// File: rtl/lane_block_scroller.sv
// Per-lane falling-block engine: spawns blocks on charted beats, scrolls
// them once per frame, judges key presses and drives the lane error flag.
// Optional build macro LANE_MISS_WRONG_EN: a missed block also raises the
// lane error flag.
module lane_block_scroller
   import bnw_pkg::*;
#(
   parameter int SPEED      = 4,
   parameter int WRONG_HOLD = 30
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           clear,
   input  logic           pause,
   input  logic           frame_tick,
   input  logic           beat_tick,
   input  logic           note,
   input  logic           key_press,
   output logic [H_W-1:0] block_1_h,
   output logic [H_W-1:0] block_2_h,
   output logic [H_W-1:0] block_3_h,
   output logic [H_W-1:0] block_4_h,
   output logic [H_W-1:0] block_5_h,
   output logic [H_W-1:0] block_6_h,
   output logic           wrong,
   output logic           hit_pulse,
   output logic           miss_pulse,
   output logic           spawn_drop
);

   localparam int CNT_W = $clog2(WRONG_HOLD + 1);

   lane_state_e          state_q, state_d;
   pos_t                 h_q [NUM_SLOTS];
   pos_t                 h_d [NUM_SLOTS];
   logic [CNT_W-1:0]     wrong_cnt_q, wrong_cnt_d;
   logic                 wrong_q, wrong_d;
   logic                 hit_pulse_q, hit_pulse_d;
   logic                 miss_pulse_q, miss_pulse_d;
   logic                 spawn_drop_q, spawn_drop_d;

   logic                 run_en;
   logic                 spawn_req;
   logic [NUM_SLOTS-1:0] empty;
   logic [NUM_SLOTS-1:0] in_win;
   logic [NUM_SLOTS-1:0] hit_cand;
   logic [NUM_SLOTS-1:0] free_grant;
   logic [NUM_SLOTS-1:0] hit_grant;
   logic                 no_free;
   logic                 no_hit;
   logic [H_W:0]         sum [NUM_SLOTS];

   // Lane state: clear wins over start; PAUSE tracks the pause level.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (start)  state_d = ST_RUN;
            ST_RUN:   if (pause)  state_d = ST_PAUSE;
            ST_PAUSE: if (!pause) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Play logic acts only while a game is in progress and not paused.
   assign run_en    = (state_q != ST_IDLE) && !pause && !clear;
   assign spawn_req = beat_tick && note;

   // Slot status plus the largest-h compare matrix over in-window slots.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         empty[i]  = (h_q[i] == '0);
         in_win[i] = in_hit_window(h_q[i]);
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
         hit_cand[i] = in_win[i];
         for (int j = 0; j < NUM_SLOTS; j++) begin
            if (in_win[j] && (h_q[j] > h_q[i])) begin
               hit_cand[i] = 1'b0;
            end
         end
      end
   end

   // Lowest empty slot receives a new block.
   lane_slot_alloc u_free_alloc (
      .req   (empty),
      .grant (free_grant),
      .none  (no_free)
   );

   // Among equally low candidates, the lowest index is judged.
   lane_slot_alloc u_hit_alloc (
      .req   (hit_cand),
      .grant (hit_grant),
      .none  (no_hit)
   );

   // Scrolled positions, one bit wider so the retire compare cannot wrap.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         sum[i] = {1'b0, h_q[i]} + (H_W + 1)'(SPEED);
      end
   end

   // Slot update, judgement, pulses and error-hold counter.
   always_comb begin
      logic retire_any;
      logic key_err;
      logic load_wrong;
      // NOTE: every always_comb output gets a default before any branch,
      // so no path leaves a signal unassigned and no latch is inferred.
      for (int i = 0; i < NUM_SLOTS; i++) begin
         h_d[i] = h_q[i];
      end
      wrong_cnt_d  = wrong_cnt_q;
      hit_pulse_d  = 1'b0;
      miss_pulse_d = 1'b0;
      spawn_drop_d = 1'b0;
      retire_any   = 1'b0;
      key_err      = 1'b0;
      load_wrong   = 1'b0;

      if (clear) begin
         // Discarded blocks vanish silently, without a miss.
         for (int i = 0; i < NUM_SLOTS; i++) begin
            h_d[i] = '0;
         end
         wrong_cnt_d = '0;
      end else if (run_en) begin
         key_err      = key_press && no_hit;
         hit_pulse_d  = key_press && !no_hit;
         spawn_drop_d = spawn_req && no_free;

         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (key_press && hit_grant[i]) begin
               // A hit takes precedence over a retire of the same slot.
               h_d[i] = '0;
            end else if (empty[i]) begin
               // Newly spawned blocks are not advanced in their load cycle.
               h_d[i] = (spawn_req && free_grant[i]) ? pos_t'(SPAWN_H) : '0;
            end else if (frame_tick) begin
               if (sum[i] >= (H_W + 1)'(RETIRE_H)) begin
                  h_d[i]     = '0;
                  retire_any = 1'b1;
               end else begin
                  h_d[i] = sum[i][H_W-1:0];
               end
            end
         end

         miss_pulse_d = retire_any;

`ifdef LANE_MISS_WRONG_EN
         load_wrong = key_err || retire_any;
`else
         load_wrong = key_err;
`endif

         if (load_wrong) begin
            wrong_cnt_d = CNT_W'(WRONG_HOLD);
         end else if (frame_tick && (wrong_cnt_q != '0)) begin
            wrong_cnt_d = wrong_cnt_q - CNT_W'(1);
         end
      end

      wrong_d = (wrong_cnt_d != '0);
   end

   // State, slot and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with <= only, so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= ST_IDLE;
         // NOTE: the slot array is a small bank of flops driving outputs,
         // not a RAM, so it is cleared on reset like any other register.
         for (int i = 0; i < NUM_SLOTS; i++) begin
            h_q[i] <= '0;
         end
         wrong_cnt_q  <= '0;
         wrong_q      <= 1'b0;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         spawn_drop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            h_q[i] <= h_d[i];
         end
         wrong_cnt_q  <= wrong_cnt_d;
         wrong_q      <= wrong_d;
         hit_pulse_q  <= hit_pulse_d;
         miss_pulse_q <= miss_pulse_d;
         spawn_drop_q <= spawn_drop_d;
      end
   end

   assign block_1_h  = h_q[0];
   assign block_2_h  = h_q[1];
   assign block_3_h  = h_q[2];
   assign block_4_h  = h_q[3];
   assign block_5_h  = h_q[4];
   assign block_6_h  = h_q[5];
   assign wrong      = wrong_q;
   assign hit_pulse  = hit_pulse_q;
   assign miss_pulse = miss_pulse_q;
   assign spawn_drop = spawn_drop_q;

endmodule

// File: tb/tb_lane_block_scroller.sv
// Scoreboard bench for lane_block_scroller: a driver applies one stimulus
// vector per clock and pushes the reference model's expected outputs; a
// monitor on the falling edge pops and compares against the DUT.
module tb_lane_block_scroller;

   localparam int SPEED = 4;
   localparam int HOLD  = 30;

   typedef struct packed {
      logic rst;
      logic start;
      logic clear;
      logic pause;
      logic frame;
      logic beat;
      logic note;
      logic key;
   } stim_t;

   typedef struct packed {
      logic [5:0][9:0] h;
      logic            wrong;
      logic            hit;
      logic            miss;
      logic            drop;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic       pause = 1'b0;
   logic       frame_tick = 1'b0;
   logic       beat_tick = 1'b0;
   logic       note = 1'b0;
   logic       key_press = 1'b0;
   logic [9:0] b1, b2, b3, b4, b5, b6;
   logic       wrong, hit_pulse, miss_pulse, spawn_drop;

   always #5 clk = ~clk;

   lane_block_scroller #(
      .SPEED      (SPEED),
      .WRONG_HOLD (HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .clear      (clear),
      .pause      (pause),
      .frame_tick (frame_tick),
      .beat_tick  (beat_tick),
      .note       (note),
      .key_press  (key_press),
      .block_1_h  (b1),
      .block_2_h  (b2),
      .block_3_h  (b3),
      .block_4_h  (b4),
      .block_5_h  (b5),
      .block_6_h  (b6),
      .wrong      (wrong),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse),
      .spawn_drop (spawn_drop)
   );

   int   n_cmp  = 0;
   int   n_fail = 0;
   obs_t exp_q[$];
   obs_t mon_exp;

   // Reference model: game running flag, block heights, error frames left.
   int   m_run = 0;
   int   m_pos [6];
   int   m_wcnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic obs_t dut_obs();
      obs_t o;
      o.h[0] = b1;
      o.h[1] = b2;
      o.h[2] = b3;
      o.h[3] = b4;
      o.h[4] = b5;
      o.h[5] = b6;
      o.wrong = wrong;
      o.hit   = hit_pulse;
      o.miss  = miss_pulse;
      o.drop  = spawn_drop;
      return o;
   endfunction

   // Game rules applied to the model for one clock with the given inputs.
   function automatic obs_t model_step(input stim_t s);
      obs_t o;
      int   pre [6];
      int   tgt;
      int   spw;
      int   nxt;
      bit   hit, miss, drop, err;
      hit = 0; miss = 0; drop = 0; err = 0;
      if (s.rst || s.clear) begin
         m_run = 0;
         for (int i = 0; i < 6; i++) m_pos[i] = 0;
         m_wcnt = 0;
      end else if (m_run == 0) begin
         if (s.start) m_run = 1;
      end else if (!s.pause) begin
         for (int i = 0; i < 6; i++) pre[i] = m_pos[i];
         tgt = -1;
         if (s.key) begin
            for (int i = 0; i < 6; i++) begin
               if (pre[i] >= 468 && pre[i] <= 599 && (tgt < 0 || pre[i] > pre[tgt])) tgt = i;
            end
            if (tgt >= 0) hit = 1;
            else          err = 1;
         end
         spw = -1;
         if (s.beat && s.note) begin
            for (int i = 5; i >= 0; i--) if (pre[i] == 0) spw = i;
            if (spw < 0) drop = 1;
         end
         for (int i = 0; i < 6; i++) begin
            if (i == tgt) begin
               m_pos[i] = 0;
            end else if (pre[i] == 0) begin
               m_pos[i] = (i == spw) ? 120 : 0;
            end else if (s.frame) begin
               nxt = pre[i] + SPEED;
               if (nxt >= 720) begin
                  m_pos[i] = 0;
                  miss = 1;
               end else begin
                  m_pos[i] = nxt;
               end
            end
         end
`ifdef LANE_MISS_WRONG_EN
         if (miss) err = 1;
`endif
         if (err)                         m_wcnt = HOLD;
         else if (s.frame && m_wcnt > 0)  m_wcnt = m_wcnt - 1;
      end
      for (int i = 0; i < 6; i++) o.h[i] = 10'(m_pos[i]);
      o.wrong = (m_wcnt != 0);
      o.hit   = hit;
      o.miss  = miss;
      o.drop  = drop;
      return o;
   endfunction

   // Drive one clock of stimulus and record what the DUT must show after it.
   task automatic step(input stim_t s);
      @(negedge clk);
      rst        = s.rst;
      start      = s.start;
      clear      = s.clear;
      pause      = s.pause;
      frame_tick = s.frame;
      beat_tick  = s.beat;
      note       = s.note;
      key_press  = s.key;
      @(posedge clk);
      exp_q.push_back(model_step(s));
   endtask

   task automatic repeat_step(input int n, input stim_t s);
      for (int i = 0; i < n; i++) step(s);
   endtask

   // Monitor: outputs are registered, so every cycle presents a result.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         check("cycle_outputs", 64'(dut_obs()), 64'(mon_exp));
      end
   end

   stim_t s_idle, s_rst, s_start, s_clear, s_spawn, s_frame, s_key, s_pframe;

   initial begin
      s_idle   = '0;
      s_rst    = '0; s_rst.rst = 1'b1;
      s_start  = '0; s_start.start = 1'b1;
      s_clear  = '0; s_clear.clear = 1'b1;
      s_spawn  = '0; s_spawn.beat = 1'b1; s_spawn.note = 1'b1;
      s_frame  = '0; s_frame.frame = 1'b1;
      s_key    = '0; s_key.key = 1'b1;
      s_pframe = '0; s_pframe.frame = 1'b1; s_pframe.pause = 1'b1;

      // Reset state.
      repeat_step(2, s_rst);
      #1;
      check("reset_block_1", 64'(b1), 64'd0);
      check("reset_wrong", 64'(wrong), 64'd0);

      // Spawn and scroll to the bottom of the hit window.
      step(s_start);
      step(s_spawn);
      #1 check("spawn_h", 64'(b1), 64'd120);
      repeat_step(87, s_frame);
      #1 check("scroll_87", 64'(b1), 64'd468);

      // Hit at the lower window edge.
      step(s_key);
      #1;
      check("hit_pulse", 64'(hit_pulse), 64'd1);
      check("hit_cleared", 64'(b1), 64'd0);
      check("hit_no_wrong", 64'(wrong), 64'd0);

      // Wrong press with no blocks: flag held for exactly HOLD frames.
      step(s_key);
      #1 check("wrong_set", 64'(wrong), 64'd1);
      repeat_step(HOLD - 1, s_frame);
      #1 check("wrong_still_set", 64'(wrong), 64'd1);
      step(s_frame);
      #1 check("wrong_expired", 64'(wrong), 64'd0);

      // Overflow: seven spawns, no scrolling.
      repeat_step(6, s_spawn);
      #1 check("no_drop_at_six", 64'(spawn_drop), 64'd0);
      step(s_spawn);
      #1;
      check("drop_at_seven", 64'(spawn_drop), 64'd1);
      check("slot6_full", 64'(b6), 64'd120);

      // Miss: untouched block retires on its 150th frame.
      step(s_clear);
      #1 check("clear_slots", 64'(b6), 64'd0);
      step(s_start);
      step(s_spawn);
      repeat_step(149, s_frame);
      #1 check("before_retire", 64'(b1), 64'd716);
      step(s_frame);
      #1;
      check("retired", 64'(b1), 64'd0);
      check("miss_pulse", 64'(miss_pulse), 64'd1);
`ifdef LANE_MISS_WRONG_EN
      check("miss_wrong", 64'(wrong), 64'd1);
`else
      check("miss_wrong", 64'(wrong), 64'd0);
`endif

      // Pause freezes positions across frames.
      step(s_spawn);
      repeat_step(5, s_frame);
      repeat_step(10, s_pframe);
      #1 check("paused_h", 64'(b1), 64'd140);
      step(s_frame);
      #1 check("resumed_h", 64'(b1), 64'd144);

      // Reset mid-run, then beats ignored until start.
      step(s_rst);
      #1 check("midrun_rst", 64'(b1), 64'd0);
      step(s_spawn);
      #1 check("idle_ignores_beat", 64'(b1), 64'd0);
      step(s_start);
      step(s_spawn);
      #1 check("restart_spawn", 64'(b1), 64'd120);

      // Randomized play against the model.
      for (int n = 0; n < 20000; n++) begin
         stim_t s;
         s       = '0;
         s.rst   = ($urandom_range(3999) == 0);
         s.clear = ($urandom_range(2999) == 0);
         s.start = ($urandom_range(63) == 0);
         s.pause = ($urandom_range(15) == 0);
         s.frame = ($urandom_range(3) == 0);
         s.beat  = ($urandom_range(5) == 0);
         s.note  = $urandom_range(1) == 1;
         s.key   = ($urandom_range(11) == 0);
         step(s);
      end

      repeat_step(2, s_idle);
      @(negedge clk);
      #1 check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
